alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter ALU_LAT, default 1, meaning ALU result latency in cycles from the alu_start cycle to the cycle alu_res is valid; legal range 1..15.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 The ports SHALL be as follows:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- rN_valid  in  1  request valid, requester N (N=0,1)
- rN_ready  out  1  request accepted when high with rN_valid
- rN_opcode  in  3  ALU opcode from requester N
- rN_op1  in  4  operand 1 from requester N
- rN_op2  in  4  operand 2 from requester N
- rN_rsp_valid  out  1  result valid to requester N
- rN_rsp_ready  in  1  requester N takes result
- rN_rsp_data  out  4  result to requester N
- alu_opcode  out  3  to ALU OPCODE
- alu_op1  out  4  to ALU OP1
- alu_op2  out  4  to ALU OP2
- alu_start  out  1  one-cycle strobe: operands valid this cycle
- alu_res  in  4  ALU result, sampled ALU_LAT cycles after alu_start
- busy  out  1  high whenever state is not IDLE

Function
REQ-004 The block SHALL implement FSM states IDLE, ISSUE, WAIT, RESP, one operation in flight at a time.
REQ-005 In IDLE, the grant SHALL be: only one valid -> that one; both valid -> the requester not equal to last_grant.
REQ-006 rN_ready SHALL be combinational and high only in IDLE, only for the granted N; never both high.
REQ-007 On rN_valid && rN_ready, the block SHALL latch opcode/op1/op2 and owner=N, and go to ISSUE next cycle.
REQ-008 alu_opcode/alu_op1/alu_op2 SHALL always drive the latched registers; opcode passed unmodified, all 8 values legal.
REQ-009 In ISSUE, alu_start SHALL be 1 for exactly that cycle, counter SHALL load ALU_LAT, next state WAIT; alu_start SHALL be 0 in all other states.
REQ-010 In WAIT, if counter==1 the block SHALL capture alu_res into the result register and go to RESP; else decrement counter and stay.
REQ-011 alu_res SHALL be ignored on every cycle except the capture cycle.
REQ-012 In RESP, owner's rN_rsp_valid SHALL be 1, non-owner's 0; both rN_rsp_data SHALL drive the result register, stable while in RESP.
REQ-013 On owner rsp_valid && rsp_ready, the block SHALL set last_grant=owner and go to IDLE; no request is accepted in that same cycle.
REQ-014 Result backpressure SHALL hold RESP indefinitely with data stable; no new grant while held.
REQ-015 Minimum occupancy SHALL be ALU_LAT+3 cycles per operation (accept, ISSUE, WAIT x ALU_LAT, RESP).
REQ-016 A requester dropping rN_valid before acceptance SHALL not be granted; the grant SHALL be re-evaluated every IDLE cycle.

Reset
REQ-017 While rst is high, the block SHALL force state IDLE, last_grant=1 (r0 wins first tie), counter/latched regs/result=0, and all outputs 0 including rN_ready.
REQ-018 Reset mid-operation SHALL discard the in-flight op: no rsp_valid after release, late alu_res ignored.

Verification
REQ-019 r0 only: opcode 3'b111, op1 4'b0100, op2 4'b1010 -> r0_ready same cycle, next cycle alu_start=1 with those values; model alu_res=4'hE -> r0_rsp_data=4'hE, r1_rsp_valid stays 0.
REQ-020 r0 and r1 valid continuously from reset release -> grants r0, r1, r0, r1; never two ready in one cycle.
REQ-021 r1_rsp_ready held low 5 cycles in RESP -> r1_rsp_valid and data held, r0_ready stays 0 despite r0_valid=1.
REQ-022 ALU_LAT=3, alu_res=4'hF except 4'h5 exactly 3 cycles after alu_start -> response data 4'h5.
REQ-023 rst pulsed during WAIT -> outputs 0 immediately, no rsp_valid after release; next request completes normally.
REQ-024 r1 only, back-to-back requests, ALU_LAT=1 -> one accept every 4 cycles, busy low only on accept cycles.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Two-requester front end for a shared, fixed-latency ALU.
//            One operation is in flight at a time. A granted request is
//            latched, issued to the ALU with a one-cycle start strobe, and
//            its result is captured exactly ALU_LAT cycles later. The result
//            is then held for the owning requester until that requester
//            accepts it. When both requesters are valid at the same time,
//            the grant alternates between them.
// Ports    : clk, rst (asynchronous, active-high)
//            rN_valid/rN_ready/rN_opcode/rN_op1/rN_op2 : request channel N
//            rN_rsp_valid/rN_rsp_ready/rN_rsp_data     : response channel N
//            alu_opcode/alu_op1/alu_op2/alu_start      : ALU issue side
//            alu_res                                   : ALU result input
//            busy                                      : high when not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int ALU_LAT = 1       // legal range 1..15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       r0_valid,
    output logic       r0_ready,
    input  logic [2:0] r0_opcode,
    input  logic [3:0] r0_op1,
    input  logic [3:0] r0_op2,
    output logic       r0_rsp_valid,
    input  logic       r0_rsp_ready,
    output logic [3:0] r0_rsp_data,
    input  logic       r1_valid,
    output logic       r1_ready,
    input  logic [2:0] r1_opcode,
    input  logic [3:0] r1_op1,
    input  logic [3:0] r1_op2,
    output logic       r1_rsp_valid,
    input  logic       r1_rsp_ready,
    output logic [3:0] r1_rsp_data,
    output logic [2:0] alu_opcode,
    output logic [3:0] alu_op1,
    output logic [3:0] alu_op2,
    output logic       alu_start,
    input  logic [3:0] alu_res,
    output logic       busy
);

    localparam logic [3:0] C_LAT = 4'(ALU_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_last_grant;
    logic       r_owner;
    logic [3:0] r_cnt;
    logic [2:0] r_opcode;
    logic [3:0] r_op1;
    logic [3:0] r_op2;
    logic [3:0] r_result;

    logic       w_idle;
    logic       w_grant1;
    logic       w_r0_ready;
    logic       w_r1_ready;
    logic       w_accept;
    logic       w_rsp_fire;

    // Grant selection. On a tie the requester that was not served last
    // wins; last_grant resets to 1 so requester 0 wins the first tie.
    // Ready is masked by rst so every output is low while reset is held.
    always_comb begin
        w_grant1 = 1'b0;
        if (r0_valid && r1_valid) begin
            w_grant1 = ~r_last_grant;
        end else if (r1_valid) begin
            w_grant1 = 1'b1;
        end
        w_idle     = (r_state == S_IDLE) && !rst;
        w_r0_ready = w_idle && r0_valid && !w_grant1;
        w_r1_ready = w_idle && r1_valid &&  w_grant1;
        w_accept   = w_r0_ready || w_r1_ready;
        w_rsp_fire = (r_state == S_RESP) &&
                     (r_owner ? r1_rsp_ready : r0_rsp_ready);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)          w_state_nxt = S_ISSUE;
            S_ISSUE:                        w_state_nxt = S_WAIT;
            S_WAIT:  if (r_cnt == 4'd1)     w_state_nxt = S_RESP;
            S_RESP:  if (w_rsp_fire)        w_state_nxt = S_IDLE;
            default:                        w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_cnt        <= 4'd0;
            r_opcode     <= 3'd0;
            r_op1        <= 4'd0;
            r_op2        <= 4'd0;
            r_result     <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_r0_ready) begin
                        r_owner  <= 1'b0;
                        r_opcode <= r0_opcode;
                        r_op1    <= r0_op1;
                        r_op2    <= r0_op2;
                    end else if (w_r1_ready) begin
                        r_owner  <= 1'b1;
                        r_opcode <= r1_opcode;
                        r_op1    <= r1_op1;
                        r_op2    <= r1_op2;
                    end
                end
                S_ISSUE: r_cnt <= C_LAT;
                S_WAIT: begin
                    // alu_res is only looked at on this single cycle, which
                    // lies exactly ALU_LAT cycles after the start strobe.
                    if (r_cnt == 4'd1) begin
                        r_result <= alu_res;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (w_rsp_fire) begin
                        r_last_grant <= r_owner;
                    end
                end
                default: ;
            endcase
        end
    end

    assign r0_ready     = w_r0_ready;
    assign r1_ready     = w_r1_ready;
    assign r0_rsp_valid = (r_state == S_RESP) && !r_owner;
    assign r1_rsp_valid = (r_state == S_RESP) &&  r_owner;
    assign r0_rsp_data  = r_result;
    assign r1_rsp_data  = r_result;
    assign alu_opcode   = r_opcode;
    assign alu_op1      = r_op1;
    assign alu_op2      = r_op2;
    assign alu_start    = (r_state == S_ISSUE);
    assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire
